// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, error codes and frame constants for uart_cmd_master.
// Defining UART_PARITY_EN adds an odd-parity bit to every frame.
package uart_pkg;

   typedef enum logic [3:0] {
      IDLE,
      TX_START,
      TX_DATA,
      TX_PAR,
      TX_STOP,
      TX_GAP,
      RX_WAIT,
      RX_START,
      RX_DATA,
      RX_PAR,
      RX_STOP,
      DONE
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_PARITY  = 2'd1;
   localparam logic [1:0] ERR_FRAME   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam int DATA_BITS  = 8;
`ifdef UART_PARITY_EN
   localparam int PAR_BITS   = 1;
`else
   localparam int PAR_BITS   = 0;
`endif

   localparam int BIT_CNT_W  = 3;
   localparam int BYTE_CNT_W = 3;

   function automatic logic odd_par(input logic [7:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: rx synchroniser, start-bit validation, bit-centre
// sampling and LSB-first byte shift for uart_cmd_master.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 hunt,
   input  logic                 run,
   input  logic                 shift_en,
   output logic                 fall,
   output logic                 start_ok,
   output logic                 false_start,
   output logic                 bit_stb,
   output logic                 bit_val,
   output logic [DATA_BITS-1:0] data
);

   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] FULL_LIM = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] HALF_LIM = BW'(CLK_DIV / 2 - 1);

   logic                 rx_s1_q, rx_s1_d;
   logic                 rx_s2_q, rx_s2_d;
   logic                 rx_prev_q, rx_prev_d;
   logic                 half_q, half_d;
   logic [BW-1:0]        cnt_q, cnt_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 smp;

   // first strobe after a start edge lands mid start bit
   assign smp = run &&
      (cnt_q == (half_q ? HALF_LIM : FULL_LIM));

   assign fall        = hunt & rx_prev_q & ~rx_s2_q;
   assign start_ok    = smp & half_q & ~rx_s2_q;
   assign false_start = smp & half_q & rx_s2_q;
   assign bit_stb     = smp & ~half_q;
   assign bit_val     = rx_s2_q;
   assign data        = sh_q;

   always_comb begin
      rx_s1_d   = rx;
      rx_s2_d   = rx_s1_q;
      rx_prev_d = rx_s2_q;
      cnt_d     = cnt_q;
      half_d    = half_q;
      sh_d      = sh_q;
      if (!run) begin
         cnt_d  = '0;
         half_d = 1'b1;
      end else if (smp) begin
         cnt_d  = '0;
         half_d = 1'b0;
      end else begin
         cnt_d  = cnt_q + BW'(1);
      end
      if (bit_stb && shift_en)
         sh_d = {rx_s2_q, sh_q[DATA_BITS-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         half_q    <= 1'b1;
         cnt_q     <= '0;
         sh_q      <= '0;
      end else begin
         rx_s1_q   <= rx_s1_d;
         rx_s2_q   <= rx_s2_d;
         rx_prev_q <= rx_prev_d;
         half_q    <= half_d;
         cnt_q     <= cnt_d;
         sh_q      <= sh_d;
      end
   end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends a command word over UART, optionally reads a reply.
// Build option UART_PARITY_EN (via uart_pkg) enables odd parity on all frames.
module uart_cmd_master
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int CMD_WIDTH  = 16,
   parameter int RD_WIDTH   = 8,
   parameter int GAP_CYCLES = 100,
   parameter int RX_TIMEOUT = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CMD_WIDTH-1:0] cmd_in,
   input  logic                 cmd_vld,
   output logic                 cmd_rdy,
   input  logic                 rx,
   output logic                 tx,
   output logic [RD_WIDTH-1:0]  rd_data,
   output logic                 rd_vld,
   output logic                 err,
   output logic [1:0]           err_code
);

   localparam int BW = $clog2(CLK_DIV);
   localparam int GW = (GAP_CYCLES > 0) ?
                       $clog2(GAP_CYCLES + 1) : 1;
   localparam int TMO = RX_TIMEOUT * CLK_DIV;
   localparam int TW = $clog2(TMO);
   localparam int TX_BYTES = CMD_WIDTH / 8;
   localparam int RX_BYTES = RD_WIDTH / 8;

   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST =
      BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BYTE_CNT_W-1:0] TXB_LAST =
      BYTE_CNT_W'(TX_BYTES - 1);
   localparam logic [BYTE_CNT_W-1:0] RXB_LAST =
      BYTE_CNT_W'(RX_BYTES - 1);

   state_t                state_q, state_d;
   logic [BW-1:0]         baud_q, baud_d;
   logic [BIT_CNT_W-1:0]  bit_q, bit_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic [BYTE_CNT_W-1:0] txb_q, txb_d;
   logic [BYTE_CNT_W-1:0] rxb_q, rxb_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic                  wr_q, wr_d;
   logic [RD_WIDTH-1:0]   rsh_q, rsh_d;
   logic [RD_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                  rd_vld_q, rd_vld_d;
   logic                  err_q, err_d;
   logic [1:0]            ec_q, ec_d;
   logic                  cmd_rdy_q, cmd_rdy_d;
   logic                  tx_q, tx_d;

   logic                  baud_end;
   logic                  frame_done;
   logic [7:0]            tx_byte;

   logic                  rx_hunt, rx_run, rx_shift;
   logic                  rx_fall, rx_start_ok, rx_false;
   logic                  rx_stb, rx_bit;
   logic [DATA_BITS-1:0]  rx_data;

   assign rx_hunt  = (state_q == RX_WAIT);
   assign rx_shift = (state_q == RX_DATA);
   assign rx_run   = (state_q == RX_START) ||
                     (state_q == RX_DATA)  ||
                     (state_q == RX_PAR)   ||
                     (state_q == RX_STOP);

   uart_rx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .hunt        (rx_hunt),
      .run         (rx_run),
      .shift_en    (rx_shift),
      .fall        (rx_fall),
      .start_ok    (rx_start_ok),
      .false_start (rx_false),
      .bit_stb     (rx_stb),
      .bit_val     (rx_bit),
      .data        (rx_data)
   );

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_d      = bit_q;
      gap_d      = gap_q;
      tmo_d      = tmo_q;
      txb_d      = txb_q;
      rxb_d      = rxb_q;
      cmd_d      = cmd_q;
      wr_d       = wr_q;
      rsh_d      = rsh_q;
      rd_data_d  = rd_data_q;
      ec_d       = ec_q;
      err_d      = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_vld && cmd_rdy_q) begin
               cmd_d   = cmd_in;
               wr_d    = cmd_in[CMD_WIDTH-1];
               txb_d   = '0;
               baud_d  = '0;
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = TX_DATA;
            end else begin
               baud_d  = baud_q + BW'(1);
            end
         end
         TX_DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST)
                  state_d = (PAR_BITS != 0) ? TX_PAR : TX_STOP;
               else
                  bit_d = bit_q + BIT_CNT_W'(1);
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         TX_PAR: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = TX_STOP;
            end else begin
               baud_d  = baud_q + BW'(1);
            end
         end
         TX_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               gap_d  = '0;
               if (GAP_CYCLES > 0)
                  state_d = TX_GAP;
               else
                  frame_done = 1'b1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         TX_GAP: begin
            if (gap_q == GAP_LAST)
               frame_done = 1'b1;
            else
               gap_d = gap_q + GW'(1);
         end
         RX_WAIT: begin
            if (rx_fall) begin
               state_d = RX_START;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               ec_d    = ERR_TIMEOUT;
               state_d = IDLE;
            end else begin
               tmo_d   = tmo_q + TW'(1);
            end
         end
         RX_START: begin
            // a false start resumes waiting with the timer intact
            if (rx_start_ok) begin
               bit_d   = '0;
               state_d = RX_DATA;
            end else if (rx_false) begin
               state_d = RX_WAIT;
            end
         end
         RX_DATA: begin
            if (rx_stb) begin
               if (bit_q == BIT_LAST)
                  state_d = (PAR_BITS != 0) ? RX_PAR : RX_STOP;
               else
                  bit_d = bit_q + BIT_CNT_W'(1);
            end
         end
         RX_PAR: begin
            if (rx_stb) begin
               if (rx_bit != odd_par(rx_data)) begin
                  err_d   = 1'b1;
                  ec_d    = ERR_PARITY;
                  state_d = IDLE;
               end else begin
                  state_d = RX_STOP;
               end
            end
         end
         RX_STOP: begin
            if (rx_stb) begin
               if (!rx_bit) begin
                  err_d   = 1'b1;
                  ec_d    = ERR_FRAME;
                  state_d = IDLE;
               end else begin
                  rsh_d = (rsh_q << 8) | RD_WIDTH'(rx_data);
                  if (rxb_q == RXB_LAST) begin
                     rd_data_d = rsh_d;
                     state_d   = DONE;
                  end else begin
                     rxb_d   = rxb_q + BYTE_CNT_W'(1);
                     tmo_d   = '0;
                     state_d = RX_WAIT;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (frame_done) begin
         if (txb_q == TXB_LAST) begin
            if (wr_q) begin
               state_d = IDLE;
            end else begin
               tmo_d   = '0;
               rxb_d   = '0;
               state_d = RX_WAIT;
            end
         end else begin
            txb_d   = txb_q + BYTE_CNT_W'(1);
            cmd_d   = cmd_q << 8;
            state_d = TX_START;
         end
      end

      // outputs are registered from next-state so they track state_q
      rd_vld_d  = (state_d == DONE);
      cmd_rdy_d = (state_d == IDLE);
      tx_byte   = cmd_d[CMD_WIDTH-1 -: 8];
      unique case (state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_byte[bit_d];
         TX_PAR:   tx_d = odd_par(tx_byte);
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         tmo_q     <= '0;
         txb_q     <= '0;
         rxb_q     <= '0;
         cmd_q     <= '0;
         wr_q      <= 1'b0;
         rsh_q     <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
         err_q     <= 1'b0;
         ec_q      <= ERR_NONE;
         cmd_rdy_q <= 1'b0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         tmo_q     <= tmo_d;
         txb_q     <= txb_d;
         rxb_q     <= rxb_d;
         cmd_q     <= cmd_d;
         wr_q      <= wr_d;
         rsh_q     <= rsh_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
         err_q     <= err_d;
         ec_q      <= ec_d;
         cmd_rdy_q <= cmd_rdy_d;
         tx_q      <= tx_d;
      end
   end

   assign cmd_rdy  = cmd_rdy_q;
   assign tx       = tx_q;
   assign rd_data  = rd_data_q;
   assign rd_vld   = rd_vld_q;
   assign err      = err_q;
   assign err_code = ec_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb_uart_cmd_master: randomized self-checking bench for uart_cmd_master.
// Expected frames and replies come from a bit-list model of the UART format.
module tb_uart_cmd_master;

   localparam int DIV = 8;
   localparam int GAP = 4;
   localparam int TMO = 4;
   localparam int CW  = 16;
   localparam int RW  = 8;
   localparam int NB  = CW / 8;
   localparam int NR  = RW / 8;
`ifdef UART_PARITY_EN
   localparam int FB  = 11;
`else
   localparam int FB  = 10;
`endif
   localparam int RX_WIN = NR * FB * DIV + 30;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] cmd_in = '0;
   logic          cmd_vld = 1'b0;
   logic          cmd_rdy;
   logic          rx = 1'b1;
   logic          tx;
   logic [RW-1:0] rd_data;
   logic          rd_vld;
   logic          err;
   logic [1:0]    err_code;

   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;
   logic [RW-1:0] exp_rd = '0;

   uart_cmd_master #(
      .CLK_DIV    (DIV),
      .CMD_WIDTH  (CW),
      .RD_WIDTH   (RW),
      .GAP_CYCLES (GAP),
      .RX_TIMEOUT (TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_in   (cmd_in),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .rx       (rx),
      .tx       (tx),
      .rd_data  (rd_data),
      .rd_vld   (rd_vld),
      .err      (err),
      .err_code (err_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog cyc=%0d limit=90000", cyc);
      $fatal(1, "watchdog");
   end

   // bit list of one frame, index 0 = start bit
   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
      if (FB == 11)
         f[9] = ($countones(d) % 2 == 0);
      return f;
   endfunction

   task automatic send_cmd(input logic [CW-1:0] c);
      int n = 0;
      while (cmd_rdy !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (cmd_rdy !== 1'b1) begin
         fails++;
         $display("FAIL rdy_wait got=%b exp=1", cmd_rdy);
      end
      cmd_in  = c;
      cmd_vld = 1'b1;
      @(negedge clk);
      cmd_vld = 1'b0;
      tests++;
      if (cmd_rdy !== 1'b0) begin
         fails++;
         $display("FAIL rdy_drop got=%b exp=0", cmd_rdy);
      end
   endtask

   task automatic check_tx(input logic [CW-1:0] c,
                           input int drop_at);
      int bad = 0;
      int k = 0;
      logic [10:0] fr;
      for (int b = NB - 1; b >= 0; b--) begin
         fr = frame_bits(c[8*b +: 8]);
         for (int i = 0; i < FB; i++) begin
            repeat (DIV) begin
               if (tx !== fr[i] || rd_vld !== 1'b0 ||
                   err !== 1'b0 || cmd_rdy !== 1'b0)
                  bad++;
               k++;
               if (k == drop_at) cmd_vld = 1'b0;
               @(negedge clk);
            end
         end
         repeat (GAP) begin
            if (tx !== 1'b1 || cmd_rdy !== 1'b0) bad++;
            k++;
            if (k == drop_at) cmd_vld = 1'b0;
            @(negedge clk);
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL tx_frames cmd=%h bad_cycles=%0d exp=0",
                  c, bad);
      end
   endtask

   task automatic watch(input int n, output int nv, output int ne,
                        output logic [RW-1:0] d,
                        output logic [1:0] ec, output int ecyc);
      nv = 0;
      ne = 0;
      d = '0;
      ec = '0;
      ecyc = -1;
      repeat (n) begin
         if (rd_vld === 1'b1) begin
            nv++;
            d = rd_data;
         end
         if (err === 1'b1) begin
            if (ne == 0) ecyc = cyc;
            ne++;
            ec = err_code;
         end
         @(negedge clk);
      end
   endtask

   task automatic reply(input logic [RW-1:0] v, input bit bad_par,
                        input bit bad_stop);
      logic [10:0] fr;
      for (int b = NR - 1; b >= 0; b--) begin
         fr = frame_bits(v[8*b +: 8]);
         if (bad_par && FB == 11) fr[9] = ~fr[9];
         if (bad_stop) fr[FB-1] = 1'b0;
         for (int i = 0; i < FB; i++) begin
            rx = fr[i];
            repeat (DIV) @(negedge clk);
         end
         rx = 1'b1;
      end
   endtask

   task automatic do_read(input logic [CW-1:0] c,
                          input logic [RW-1:0] v, input bit glitch);
      int nv, ne, ecyc;
      logic [RW-1:0] d;
      logic [1:0] ec;
      send_cmd(c);
      check_tx(c, 0);
      fork
         begin
            if (glitch) begin
               rx = 1'b0;
               repeat (3) @(negedge clk);
               rx = 1'b1;
               repeat (6) @(negedge clk);
            end
            reply(v, 1'b0, 1'b0);
         end
         watch(RX_WIN + (glitch ? 9 : 0), nv, ne, d, ec, ecyc);
      join
      tests++;
      if (nv != 1 || ne != 0) begin
         fails++;
         $display("FAIL rd_strobes vld=%0d err=%0d exp=1,0", nv, ne);
      end
      tests++;
      if (d !== v) begin
         fails++;
         $display("FAIL rd_value got=%h exp=%h", d, v);
      end
      exp_rd = v;
      tests++;
      if (rd_data !== exp_rd) begin
         fails++;
         $display("FAIL rd_hold got=%h exp=%h", rd_data, exp_rd);
      end
   endtask

   task automatic do_write(input logic [CW-1:0] c);
      send_cmd(c);
      check_tx(c, 0);
      tests++;
      if (cmd_rdy !== 1'b1 || rd_vld !== 1'b0) begin
         fails++;
         $display("FAIL wr_done rdy=%b vld=%b exp=1,0",
                  cmd_rdy, rd_vld);
      end
   endtask

   task automatic read_err(input bit bad_par, input bit bad_stop,
                           input logic [1:0] code, input bit silent);
      int nv, ne, ecyc, t0;
      logic [RW-1:0] d;
      logic [1:0] ec;
      logic [CW-1:0] c;
      c = CW'($urandom) & ~(CW'(1) << (CW - 1));
      send_cmd(c);
      check_tx(c, 0);
      t0 = cyc;
      if (silent)
         watch(TMO * DIV + 20, nv, ne, d, ec, ecyc);
      else
         fork
            reply(RW'($urandom), bad_par, bad_stop);
            watch(RX_WIN, nv, ne, d, ec, ecyc);
         join
      tests++;
      if (ne != 1 || ec !== code || nv != 0) begin
         fails++;
         $display("FAIL err_code n=%0d code=%0d vld=%0d exp=1,%0d,0",
                  ne, ec, nv, code);
      end
      tests++;
      if (rd_data !== exp_rd) begin
         fails++;
         $display("FAIL err_keep got=%h exp=%h", rd_data, exp_rd);
      end
      if (silent) begin
         tests++;
         if (ecyc - t0 != TMO * DIV) begin
            fails++;
            $display("FAIL tmo_delay got=%0d exp=%0d",
                     ecyc - t0, TMO * DIV);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if (tx !== 1'b1 || cmd_rdy !== 1'b0) begin
         fails++;
         $display("FAIL rst_tx_rdy got=%b%b exp=10", tx, cmd_rdy);
      end
      tests++;
      if (rd_vld !== 1'b0 || err !== 1'b0 || err_code !== 2'd0) begin
         fails++;
         $display("FAIL rst_strb got=%b%b%0d exp=000",
                  rd_vld, err, err_code);
      end
      tests++;
      if (rd_data !== '0) begin
         fails++;
         $display("FAIL rst_data got=%h exp=0", rd_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (cmd_rdy !== 1'b1) begin
         fails++;
         $display("FAIL rst_rdy_rise got=%b exp=1", cmd_rdy);
      end
   endtask

   task automatic test_write();
      logic [CW-1:0] c;
      do_write(16'h8A5C);
      for (int i = 0; i < 3; i++) begin
         c = CW'($urandom) | (CW'(1) << (CW - 1));
         do_write(c);
      end
   endtask

   task automatic test_ignore();
      send_cmd(16'hC3A1);
      cmd_in  = 16'h0FF0;
      cmd_vld = 1'b1;
      check_tx(16'hC3A1, 30);
      tests++;
      if (cmd_rdy !== 1'b1) begin
         fails++;
         $display("FAIL ignore_rdy got=%b exp=1", cmd_rdy);
      end
   endtask

   task automatic test_read();
      do_read(16'h0012, 8'hC3, 1'b0);
      for (int i = 0; i < 3; i++)
         do_read(CW'($urandom) & ~(CW'(1) << (CW - 1)),
                 RW'($urandom), 1'b0);
   endtask

   task automatic test_glitch();
      do_read(16'h0034, RW'($urandom), 1'b1);
   endtask

   task automatic test_back_to_back();
      logic [CW-1:0] w;
      w = CW'($urandom) | (CW'(1) << (CW - 1));
      do_write(w);
      do_read(CW'($urandom) & ~(CW'(1) << (CW - 1)),
              RW'($urandom), 1'b0);
   endtask

   task automatic test_midframe_reset();
      int nv, ne, ecyc;
      logic [RW-1:0] d;
      logic [1:0] ec;
      send_cmd(16'hF0F0);
      repeat (19) @(negedge clk);
      tests++;
      if (tx !== 1'b0) begin
         fails++;
         $display("FAIL mid_pre_tx got=%b exp=0", tx);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (tx !== 1'b1 || cmd_rdy !== 1'b0) begin
         fails++;
         $display("FAIL mid_rst got=%b%b exp=10", tx, cmd_rdy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      exp_rd = '0;
      tests++;
      if (cmd_rdy !== 1'b1 || rd_data !== exp_rd) begin
         fails++;
         $display("FAIL mid_release rdy=%b data=%h exp=1,%h",
                  cmd_rdy, rd_data, exp_rd);
      end
      watch(100, nv, ne, d, ec, ecyc);
      tests++;
      if (nv != 0 || ne != 0 || tx !== 1'b1) begin
         fails++;
         $display("FAIL mid_quiet vld=%0d err=%0d tx=%b exp=0,0,1",
                  nv, ne, tx);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_ignore();
      test_read();
      read_err(1'b0, 1'b1, 2'd2, 1'b0);
      read_err(1'b0, 1'b0, 2'd3, 1'b1);
      test_glitch();
      test_back_to_back();
`ifdef UART_PARITY_EN
      read_err(1'b1, 1'b0, 2'd1, 1'b0);
`endif
      test_midframe_reset();
      do_read(16'h0012, 8'hC3, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
